// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Shares the single register-file write port (GPR and FPR)
//            between the in-order pipeline writeback and a long-latency
//            execution unit. Pipeline writeback always wins. Long-latency
//            results wait in a small circular FIFO and drain into idle
//            writeback cycles. Pending destinations are reported to the
//            decode-stage hazard logic, and a bubble is requested while the
//            queue is full.
// Ports    : clk, reset                 - clock, async active-high reset
//            wb_we/wb_fp/wb_rw/wb_data  - pipeline writeback request
//            lu_valid/lu_fp/lu_rw/lu_data, lu_ready - long-latency handshake
//            Rs_ID, Rt_ID, pend_hit     - decode hazard lookup
//            drain_req                  - queue full, bubble request
//            reg_we, freg_we, Rw, BUS_W, FBUS_W - registered write port
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_we,
    input  logic              wb_fp,
    input  logic [ADDR_W-1:0] wb_rw,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              lu_valid,
    input  logic              lu_fp,
    input  logic [ADDR_W-1:0] lu_rw,
    input  logic [DATA_W-1:0] lu_data,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] Rs_ID,
    input  logic [ADDR_W-1:0] Rt_ID,
    output logic              pend_hit,
    output logic              drain_req,
    output logic              reg_we,
    output logic              freg_we,
    output logic [ADDR_W-1:0] Rw,
    output logic [DATA_W-1:0] BUS_W,
    output logic [DATA_W-1:0] FBUS_W
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_PTR_W = c_IDX_W + 1;

    // Queue storage and pointers (low bits index, MSB is the wrap bit)
    logic              r_ent_fp   [DEPTH];
    logic [ADDR_W-1:0] r_ent_rw   [DEPTH];
    logic [DATA_W-1:0] r_ent_data [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;

    // Registered write port
    logic              r_reg_we;
    logic              r_freg_we;
    logic [ADDR_W-1:0] r_rw;
    logic [DATA_W-1:0] r_bus_w;
    logic [DATA_W-1:0] r_fbus_w;

    logic               w_full;
    logic               w_empty;
    logic [c_PTR_W-1:0] w_count;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic               w_push;
    logic               w_store;
    logic               w_pop;
    logic               w_push_hit;
    logic [DEPTH-1:0]   w_ent_valid;
    logic [DEPTH-1:0]   w_ent_hit;

    logic              w_sel_valid;
    logic              w_sel_fp;
    logic [ADDR_W-1:0] w_sel_rw;
    logic [DATA_W-1:0] w_sel_data;

    assign w_wr_idx = r_wr_ptr[c_IDX_W-1:0];
    assign w_rd_idx = r_rd_ptr[c_IDX_W-1:0];
    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (w_wr_idx == w_rd_idx) &&
                      (r_wr_ptr[c_PTR_W-1] != r_rd_ptr[c_PTR_W-1]);

    // Acceptance depends on registered occupancy only: a pop in the same
    // cycle never opens a slot for a push while full.
    assign lu_ready  = !w_full;
    assign drain_req = w_full;
    assign w_push    = lu_valid && lu_ready;
    // GPR r0 results complete the handshake but are never stored.
    assign w_store   = w_push && (lu_fp || (lu_rw != '0));
    // Pipeline writeback has priority; a freshly pushed entry is not
    // visible to the pop logic until the next cycle (no bypass).
    assign w_pop     = !wb_we && !w_empty;

    // Service selection
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_fp    = 1'b0;
        w_sel_rw    = '0;
        w_sel_data  = '0;
        if (wb_we) begin
            w_sel_valid = 1'b1;
            w_sel_fp    = wb_fp;
            w_sel_rw    = wb_rw;
            w_sel_data  = wb_data;
        end else if (w_pop) begin
            w_sel_valid = 1'b1;
            w_sel_fp    = r_ent_fp[w_rd_idx];
            w_sel_rw    = r_ent_rw[w_rd_idx];
            w_sel_data  = r_ent_data[w_rd_idx];
        end
    end

    // Queue storage and pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent_fp[i]   <= 1'b0;
                r_ent_rw[i]   <= '0;
                r_ent_data[i] <= '0;
            end
        end else begin
            if (w_store) begin
                r_ent_fp[w_wr_idx]   <= lu_fp;
                r_ent_rw[w_wr_idx]   <= lu_rw;
                r_ent_data[w_wr_idx] <= lu_data;
                r_wr_ptr             <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Write-port output register. Each data bus only changes when its own
    // file is the target, so the other file's bus holds its last value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reg_we  <= 1'b0;
            r_freg_we <= 1'b0;
            r_rw      <= '0;
            r_bus_w   <= '0;
            r_fbus_w  <= '0;
        end else begin
            r_reg_we  <= w_sel_valid && !w_sel_fp && (w_sel_rw != '0);
            r_freg_we <= w_sel_valid && w_sel_fp;
            if (w_sel_valid) begin
                r_rw <= w_sel_rw;
                if (w_sel_fp) begin
                    r_fbus_w <= w_sel_data;
                end else begin
                    r_bus_w <= w_sel_data;
                end
            end
        end
    end

    // Hazard lookup: an entry is live when its distance from the read
    // pointer is below the occupancy count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [c_IDX_W-1:0] w_off;
        assign w_off           = c_IDX_W'(gi) - w_rd_idx;
        assign w_ent_valid[gi] = ({1'b0, w_off} < w_count);
        assign w_ent_hit[gi]   = w_ent_valid[gi] &&
                                 (r_ent_fp[gi] || (r_ent_rw[gi] != '0)) &&
                                 ((r_ent_rw[gi] == Rs_ID) || (r_ent_rw[gi] == Rt_ID));
    end

    assign w_push_hit = w_push && (lu_fp || (lu_rw != '0)) &&
                        ((lu_rw == Rs_ID) || (lu_rw == Rt_ID));
    assign pend_hit   = w_push_hit || (|w_ent_hit);

    assign reg_we  = r_reg_we;
    assign freg_we = r_freg_we;
    assign Rw      = r_rw;
    assign BUS_W   = r_bus_w;
    assign FBUS_W  = r_fbus_w;

endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port (GPR and FPR) between the in-order pipeline writeback and a long-latency execution unit (multiply/divide/FP) that returns results out of band. Pipeline writeback always wins. Long-latency results are queued in a small FIFO and drained into idle writeback cycles. The block also reports pending destination registers to the decode-stage hazard logic, and requests a pipeline bubble when the queue is full.

## Interface
- DATA_W, 32, width of write data
- ADDR_W, 5, register address width
- DEPTH, 2, long-latency result queue entries (power of two, ≥2)

- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- wb_we  in  1  pipeline writeback valid this cycle
- wb_fp  in  1  pipeline target: 1 = FPR, 0 = GPR
- wb_rw  in  ADDR_W  pipeline destination register
- wb_data  in  DATA_W  pipeline result
- lu_valid  in  1  long-latency unit offers a result
- lu_fp  in  1  long-latency target file
- lu_rw  in  ADDR_W  long-latency destination
- lu_data  in  DATA_W  long-latency result
- lu_ready  out  1  queue accepts; transfer occurs when lu_valid & lu_ready
- Rs_ID, Rt_ID  in  ADDR_W  decode-stage source registers
- pend_hit  out  1  a queued or accepting entry targets Rs_ID or Rt_ID (same file class ignored; any match counts)
- drain_req  out  1  queue full; pipeline must insert a bubble
- reg_we  out  1  GPR write enable
- freg_we  out  1  FPR write enable
- Rw  out  ADDR_W  write address to both files
- BUS_W  out  DATA_W  GPR write data
- FBUS_W  out  DATA_W  FPR write data

## Operation
- Queue: circular FIFO, DEPTH entries of {fp, rw, data}. Read and write pointers have ADDR bits log2(DEPTH) plus 1 wrap bit. Full = pointer low bits equal with wrap bits differing. Empty = pointers equal.
- Push: lu_valid & lu_ready. lu_ready = !full, decided from the registered count only. There is no push-while-full, even if a pop happens in the same cycle.
- GPR r0 filter: a push with lu_fp=0 and lu_rw=0 completes the handshake but is discarded and does not enter the queue. A pipeline write with wb_fp=0 and wb_rw=0 produces no write (reg_we stays 0).
- Service per cycle:
  - If wb_we, the pipeline write is selected.
  - Otherwise, if the queue is non-empty, the head is popped and selected.
  - Otherwise, idle.
- A pushed entry is never popped in its own push cycle. There is no bypass.
- Selected write goes to the output register:
  - reg_we = !fp & (rw≠0); freg_we = fp; Rw = rw.
  - BUS_W = data when !fp, else holds its previous value. FBUS_W follows the same rule for fp.
- Ordering between the two streams is in service order only. RAW/WAW correctness is the hazard logic's job, using pend_hit.
- pend_hit (combinational) = OR over valid queue entries and the current accepted push of (rw==Rs_ID | rw==Rt_ID), excluding rw==0 with fp=0.
- drain_req = full (registered-count derived).

## Timing
- Reset values: reg_we=0, freg_we=0, Rw=0, BUS_W=0, FBUS_W=0, both pointers 0, lu_ready=1, drain_req=0. pend_hit reflects only the input-side push term.
- Reset mid-operation: queued entries are lost and no write is issued. The long-latency unit is reset together with this block.
- Pipeline write latency: wb_* at edge N appears on the write port after edge N, so the register file captures it at edge N+1.
- Long-latency latency: minimum 2 cycles. Push at edge N; earliest pop at edge N+1 if wb_we=0 in that cycle; port output after N+1.
- Starvation: with continuous wb_we the queue never drains. drain_req forces a bubble cycle, which pops exactly one entry. lu_ready returns to 1 the cycle after that pop.
- Simultaneous push and pop when non-full: count unchanged, pointers both advance.

## Test plan
- Reset then idle: all outputs 0 and lu_ready=1 until the first transaction. Assert reset mid-queue with 2 entries: outputs 0 next cycle, queue empty.
- wb_we=1, wb_fp=0, wb_rw=5, wb_data=0x1234: next cycle reg_we=1, Rw=5, BUS_W=0x1234, freg_we=0. Same with wb_rw=0: reg_we=0.
- lu push {fp=1, rw=3, 0xDEAD} with wb_we=0: freg_we=1, Rw=3, FBUS_W=0xDEAD two cycles after the push edge. pend_hit=1 with Rs_ID=3 during the queued cycle.
- wb_we held 1, two lu pushes: drain_req=1 and lu_ready=0. A third lu_valid is not accepted. Drop wb_we for one cycle: the first entry (FIFO order) is written, then lu_ready=1.
- Push and pop in the same cycle with 1 entry queued: count stays 1. Order is preserved across pointer wrap over 6 successive entries.
- lu push {fp=0, rw=0}: handshake completes, queue stays empty, no write ever issued, pend_hit=0 for Rs_ID=0.
